uart_status_tx: RTL

//  Upstream companion of the UART register mapper: returns acknowledge/status frames on

---
 rtl/uart_status_tx_pkg.sv | 45 ++++
 rtl/uart_status_tx_byte.sv | 104 ++++++++++
 rtl/uart_status_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_status_tx_pkg.sv
// Shared definitions for the UART status/acknowledge transmitter: frame constants,
// FSM encodings and the frame payload layout.
package uart_status_tx_pkg;

  localparam logic [7:0]  FRAME_HDR = 8'hA5;
  localparam int unsigned FRAME_LEN = 6;
  localparam int unsigned FLAG_ACK  = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } frm_state_e;

  typedef enum logic [1:0] {
    BT_IDLE,
    BT_START,
    BT_DATA,
    BT_STOP
  } bit_state_e;

  // Bytes 1..5 of a frame; byte 0 is always FRAME_HDR
  typedef struct packed {
    logic [7:0] func;
    logic [7:0] busy;
    logic [7:0] valid;
    logic [7:0] flags;
    logic [7:0] csum;
  } frame_t;

  function automatic logic [7:0] frame_byte(input frame_t f, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd1:    b = f.func;
      3'd2:    b = f.busy;
      3'd3:    b = f.valid;
      3'd4:    b = f.flags;
      3'd5:    b = f.csum;
      default: b = FRAME_HDR;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_status_tx_byte.sv
// 8N1 byte serializer: START, 8 data bits LSB first, STOP, each BAUD_CNT cycles.
// A start seen on the last STOP cycle chains the next byte with no idle gap.
module uart_status_tx_byte
  import uart_status_tx_pkg::*;
#(
  parameter int unsigned BAUD_CNT = 434
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy_c,
  output logic       done_c,
  output logic       txd
);

  localparam int unsigned          CNT_W    = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BAUD_CNT - 1);

  bit_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             txd_q, txd_d;
  logic             tick;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    tick    = (cnt_q == CNT_LAST);
    busy_c  = (state_q != BT_IDLE);
    done_c  = (state_q == BT_STOP) && tick;

    if (state_q != BT_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      BT_IDLE: begin
        if (start) begin
          state_d = BT_START;
          cnt_d   = '0;
          sh_d    = data;
          txd_d   = 1'b0;
        end
      end
      BT_START: begin
        if (tick) begin
          state_d = BT_DATA;
          bit_d   = 3'd0;
          txd_d   = sh_q[0];
        end
      end
      BT_DATA: begin
        // txd is registered, so it is loaded with the bit for the coming slot
        if (tick) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = BT_STOP;
            txd_d   = 1'b1;
          end else begin
            sh_d  = sh_q >> 1;
            txd_d = sh_q[1];
          end
        end
      end
      BT_STOP: begin
        if (tick) begin
          if (start) begin
            state_d = BT_START;
            sh_d    = data;
            txd_d   = 1'b0;
          end else begin
            state_d = BT_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: state_d = BT_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q <= BT_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'h00;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

  assign txd = txd_q;

endmodule

// File: rtl/uart_status_tx.sv
// Status/acknowledge frame transmitter: captures accepted commands and pwm_valid rising
// edges, and sends each as a 6-byte frame through the byte serializer.
module uart_status_tx
  import uart_status_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned UART_BPS      = 115200,
  parameter int unsigned _NUM_CHANNELS = 4
) (
  input  logic                     clk_50M,
  input  logic                     rst,
  input  logic [7:0]               func_reg,
  input  logic                     pack_done,
  input  logic [_NUM_CHANNELS-1:0] pwm_busy,
  input  logic [_NUM_CHANNELS-1:0] pwm_valid,
  input  logic                     tx_en,
  output logic                     uart_txd,
  output logic                     tx_busy,
  output logic                     frame_done,
  output logic [7:0]               ack_ovr
);

  localparam int unsigned N        = _NUM_CHANNELS;
  localparam int unsigned BAUD_CNT = CLK_FREQ / UART_BPS;

  frm_state_e state_q, state_d;
  logic       ack_pend_q, ack_pend_d;
  logic [7:0] ack_func_q, ack_func_d;
  logic [N-1:0] evt_pend_q, evt_pend_d;
  logic [N-1:0] valid_prev_q, valid_prev_d;
  logic [7:0] ack_ovr_q, ack_ovr_d;
  frame_t     frame_q, frame_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  logic       tx_busy_q, tx_busy_d;
  logic       frame_done_q, frame_done_d;

  logic [N-1:0] evt_rise;
  logic [7:0]   flags_v;
  logic         ack_clr, evt_clr;
  logic         byte_start_c, byte_busy_c, byte_done_c;
  logic [7:0]   byte_data_c;

  always_comb begin
    state_d      = state_q;
    ack_pend_d   = ack_pend_q;
    ack_func_d   = ack_func_q;
    evt_pend_d   = evt_pend_q;
    ack_ovr_d    = ack_ovr_q;
    frame_d      = frame_q;
    byte_idx_d   = byte_idx_q;
    valid_prev_d = pwm_valid;
    byte_start_c = 1'b0;
    byte_data_c  = FRAME_HDR;
    ack_clr      = 1'b0;
    evt_clr      = 1'b0;
    flags_v      = 8'h00;
    evt_rise     = pwm_valid & ~valid_prev_q;

    case (state_q)
      ST_IDLE: begin
        if (tx_en && !byte_busy_c && (ack_pend_q || (evt_pend_q != '0))) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Ack wins when both kinds are pending; header byte goes out immediately
        if (ack_pend_q) begin
          flags_v[FLAG_ACK] = 1'b1;
          ack_clr           = 1'b1;
        end else begin
          flags_v = 8'(evt_pend_q);
          evt_clr = 1'b1;
        end
        frame_d.func  = ack_pend_q ? ack_func_q : 8'h00;
        frame_d.busy  = 8'(pwm_busy);
        frame_d.valid = 8'(pwm_valid);
        frame_d.flags = flags_v;
        frame_d.csum  = FRAME_HDR + frame_d.func + frame_d.busy + frame_d.valid + flags_v;
        byte_start_c  = 1'b1;
        byte_data_c   = FRAME_HDR;
        byte_idx_d    = 3'd1;
        state_d       = ST_SEND;
      end
      ST_SEND: begin
        if (byte_done_c) begin
          if (byte_idx_q == 3'(FRAME_LEN)) begin
            state_d = ST_DONE;
          end else begin
            byte_start_c = 1'b1;
            byte_data_c  = frame_byte(frame_q, byte_idx_q);
            byte_idx_d   = byte_idx_q + 3'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // New captures override the clear of the flag being served
    ack_pend_d = ack_pend_q && !ack_clr;
    if (pack_done) begin
      ack_pend_d = 1'b1;
      ack_func_d = func_reg;
      if (ack_pend_q && (ack_ovr_q != 8'hFF)) begin
        ack_ovr_d = ack_ovr_q + 8'd1;
      end
    end
    evt_pend_d = (evt_clr ? '0 : evt_pend_q) | evt_rise;

    tx_busy_d    = (state_d == ST_LOAD) || (state_d == ST_SEND);
    frame_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ack_pend_q   <= 1'b0;
      ack_func_q   <= 8'h00;
      evt_pend_q   <= '0;
      valid_prev_q <= '0;
      ack_ovr_q    <= 8'h00;
      frame_q      <= '0;
      byte_idx_q   <= 3'd0;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_pend_q   <= ack_pend_d;
      ack_func_q   <= ack_func_d;
      evt_pend_q   <= evt_pend_d;
      valid_prev_q <= valid_prev_d;
      ack_ovr_q    <= ack_ovr_d;
      frame_q      <= frame_d;
      byte_idx_q   <= byte_idx_d;
      tx_busy_q    <= tx_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  uart_status_tx_byte #(
    .BAUD_CNT (BAUD_CNT)
  ) u_byte (
    .clk_50M (clk_50M),
    .rst     (rst),
    .start   (byte_start_c),
    .data    (byte_data_c),
    .busy_c  (byte_busy_c),
    .done_c  (byte_done_c),
    .txd     (uart_txd)
  );

  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;
  assign ack_ovr    = ack_ovr_q;

endmodule
